// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller.
//   fc_state_e : FSM state encoding (RUN, EXT, CTRL, DRAIN, HALTED)
//   clog2      : ceiling log2 usable in constant expressions
//   max3       : largest of three values, for sizing the cycle counter
//   span_load  : counter preload for an N-cycle span, clamped to the counter range
package flow_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_EXT    = 3'd1,
      ST_CTRL   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } fc_state_e;

   // Ceiling log2; returns 0 for inputs of 0 or 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // A down-counter loaded with N-1 spends N cycles before reaching zero.
   // A zero-length span still occupies one cycle.
   function automatic int unsigned span_load(input int unsigned cycles,
                                             input int unsigned cnt_max);
      int unsigned v;
      v = (cycles == 0) ? 0 : cycles - 1;
      if (v > cnt_max) v = cnt_max;
      return v;
   endfunction

endpackage

// File: rtl/flow_cycle_counter.sv
// Load/decrement cycle counter with a registered zero flag.
//   clk, rst_n   : clock, async active-low reset (counter clears to 0)
//   load_i       : load load_val_i (has priority over decrement)
//   load_val_i   : preload value
//   dec_i        : decrement request; ignored when already zero (no wrap)
//   zero_o       : counter currently holds zero
module flow_cycle_counter
   import flow_ctrl_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         zero_q;

   // Next count: load wins, decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// IF/ID flow controller for the 16-bit RISC pipeline: sequences multi-word
// extended instructions, post-control IF squash, halt drain and a sticky
// HALTED state released by a resume pulse.
//   clk, reset         : clock, async active-low reset
//   id_is_extended     : ID holds an extended instruction
//   id_ext_words       : extension word count (0 treated as 1)
//   id_is_control      : ID holds a control-flow instruction
//   id_is_halt         : ID holds a halt
//   vfu_stall_at_id/ex : forwarding unit stall requests
//   resume             : pulse that leaves HALTED
//   stall_if/stall_id  : hold IF / ID registers
//   squash_if/id/ex    : bubble IF / ID / EX
//   extended_ld        : fetched word is an extension word
//   ext_index          : 0-based index of that extension word
//   halt, busy         : halted / FSM not in RUN
module pipeline_flow_ctrl
   import flow_ctrl_pkg::*;
#(
   parameter int unsigned EXT_CNT_W   = 2,
   parameter int unsigned CTRL_SQUASH = 1,
   parameter int unsigned HALT_DRAIN  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_is_extended,
   input  logic [EXT_CNT_W-1:0] id_ext_words,
   input  logic                 id_is_control,
   input  logic                 id_is_halt,
   input  logic                 vfu_stall_at_id,
   input  logic                 vfu_stall_at_ex,
   input  logic                 resume,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 squash_if,
   output logic                 squash_id,
   output logic                 squash_ex,
   output logic                 extended_ld,
   output logic [EXT_CNT_W-1:0] ext_index,
   output logic                 halt,
   output logic                 busy
);

   localparam int unsigned EXT_SPAN   = 32'(1) << EXT_CNT_W;
   localparam int unsigned CNT_W      = clog2(max3(EXT_SPAN, CTRL_SQUASH, HALT_DRAIN)) + 1;
   localparam int unsigned CNT_MAX    = (32'(1) << CNT_W) - 1;
   localparam int unsigned CTRL_LOAD  = span_load(CTRL_SQUASH, CNT_MAX);
   localparam int unsigned DRAIN_LOAD = span_load(HALT_DRAIN, CNT_MAX);

   fc_state_e            state_q, state_d;
   logic                 cnt_load;
   logic [CNT_W-1:0]     cnt_load_val;
   logic                 cnt_dec;
   logic                 cnt_zero;
   logic [EXT_CNT_W-1:0] ext_index_q, ext_index_d;
   logic                 squash_ex_q;
   logic                 vfu_squash_q;
   logic [CNT_W-1:0]     ext_load;

   // Extension word count of 0 behaves like 1; words-1 always fits CNT_W.
   assign ext_load = (id_ext_words == '0) ? '0
                                          : CNT_W'(id_ext_words - EXT_CNT_W'(1));

   flow_cycle_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, counter control and extension index.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      ext_index_d  = '0;
      unique case (state_q)
         ST_RUN: begin
            if (id_is_extended && !vfu_stall_at_ex) begin
               state_d      = ST_EXT;
               cnt_load     = 1'b1;
               cnt_load_val = ext_load;
            end else if (id_is_control && !vfu_stall_at_id) begin
               state_d      = ST_CTRL;
               cnt_load     = 1'b1;
               cnt_load_val = CNT_W'(CTRL_LOAD);
            end else if (id_is_halt && !vfu_stall_at_ex) begin
               state_d      = ST_DRAIN;
               cnt_load     = 1'b1;
               cnt_load_val = CNT_W'(DRAIN_LOAD);
            end
         end
         ST_EXT: begin
            if (cnt_zero) begin
               state_d = ST_RUN;
            end else begin
               cnt_dec     = 1'b1;
               ext_index_d = ext_index_q + EXT_CNT_W'(1);
            end
         end
         ST_CTRL: begin
            if (cnt_zero) state_d = ST_RUN;
            else          cnt_dec = 1'b1;
         end
         ST_DRAIN: begin
            if (cnt_zero) state_d = ST_HALTED;
            else          cnt_dec = 1'b1;
         end
         ST_HALTED: begin
            if (resume) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Output decode; stall outputs track the forwarding unit even in reset.
   always_comb begin
      stall_id    = vfu_stall_at_ex;
      stall_if    = (vfu_stall_at_ex & ~id_is_control) | vfu_stall_at_id;
      squash_if   = 1'b0;
      squash_id   = vfu_squash_q;
      extended_ld = 1'b0;
      halt        = 1'b0;
      busy        = (state_q != ST_RUN);
      unique case (state_q)
         ST_EXT: begin
            extended_ld = 1'b1;
            squash_id   = 1'b1;
         end
         ST_CTRL, ST_DRAIN: begin
            squash_if = 1'b1;
         end
         ST_HALTED: begin
            squash_if = 1'b1;
            stall_if  = 1'b1;
            halt      = 1'b1;
         end
         default: ;
      endcase
   end

   // Extension index and forwarding-unit bubbles, one cycle behind their cause.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_index_q  <= '0;
         squash_ex_q  <= 1'b0;
         vfu_squash_q <= 1'b0;
      end else begin
         ext_index_q  <= ext_index_d;
         squash_ex_q  <= vfu_stall_at_ex;
         vfu_squash_q <= vfu_stall_at_id & ~vfu_stall_at_ex;
      end
   end

   assign ext_index = ext_index_q;
   assign squash_ex = squash_ex_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl (EXT_CNT_W=2, CTRL_SQUASH=2, HALT_DRAIN=3).
module tb_pipeline_flow_ctrl;

   logic       clk;
   logic       reset;
   logic       id_is_extended;
   logic [1:0] id_ext_words;
   logic       id_is_control;
   logic       id_is_halt;
   logic       vfu_stall_at_id;
   logic       vfu_stall_at_ex;
   logic       resume;
   logic       stall_if, stall_id, squash_if, squash_id, squash_ex;
   logic       extended_ld, halt, busy;
   logic [1:0] ext_index;

   int checks = 0;
   int errors = 0;

   pipeline_flow_ctrl #(
      .EXT_CNT_W   (2),
      .CTRL_SQUASH (2),
      .HALT_DRAIN  (3)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_is_extended  (id_is_extended),
      .id_ext_words    (id_ext_words),
      .id_is_control   (id_is_control),
      .id_is_halt      (id_is_halt),
      .vfu_stall_at_id (vfu_stall_at_id),
      .vfu_stall_at_ex (vfu_stall_at_ex),
      .resume          (resume),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .squash_if       (squash_if),
      .squash_id       (squash_id),
      .squash_ex       (squash_ex),
      .extended_ld     (extended_ld),
      .ext_index       (ext_index),
      .halt            (halt),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_is_extended  = 1'b0;
      id_ext_words    = 2'd0;
      id_is_control   = 1'b0;
      id_is_halt      = 1'b0;
      vfu_stall_at_id = 1'b0;
      vfu_stall_at_ex = 1'b0;
      resume          = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_in();
      reset = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_halt", 32'(halt), 0);
      chk("rst_sq_if", 32'(squash_if), 0);
      chk("rst_sq_id", 32'(squash_id), 0);
      chk("rst_sq_ex", 32'(squash_ex), 0);
      chk("rst_extld", 32'(extended_ld), 0);
      chk("rst_idx", 32'(ext_index), 0);
      chk("rst_stall_if", 32'(stall_if), 0);
      reset = 1'b1;
      tick();

      // Three-word extension: indices 0,1,2 then back to RUN.
      id_is_extended = 1'b1; id_ext_words = 2'd3;
      tick(); clear_in();
      for (int i = 0; i < 3; i++) begin
         chk("ext3_ld", 32'(extended_ld), 1);
         chk("ext3_sqid", 32'(squash_id), 1);
         chk("ext3_idx", 32'(ext_index), 32'(i));
         tick();
      end
      chk("ext3_done_busy", 32'(busy), 0);
      chk("ext3_done_ld", 32'(extended_ld), 0);
      chk("ext3_done_sqid", 32'(squash_id), 0);

      // Control: two squash cycles.
      id_is_control = 1'b1;
      tick(); clear_in();
      chk("ctrl_sqif0", 32'(squash_if), 1);
      tick();
      chk("ctrl_sqif1", 32'(squash_if), 1);
      tick();
      chk("ctrl_sqif_end", 32'(squash_if), 0);
      chk("ctrl_busy_end", 32'(busy), 0);

      // Control blocked by ID stall; stall_if asserted; bubble in ID next cycle.
      id_is_control = 1'b1; vfu_stall_at_id = 1'b1;
      #1 chk("ctrl_blk_stall_if", 32'(stall_if), 1);
      tick(); clear_in();
      chk("ctrl_blk_busy", 32'(busy), 0);
      chk("ctrl_blk_sqif", 32'(squash_if), 0);
      chk("vfu_bubble_sqid", 32'(squash_id), 1);
      tick();
      chk("vfu_bubble_gone", 32'(squash_id), 0);

      // Halt: 3 drain cycles (resume ignored), then sticky HALTED.
      id_is_halt = 1'b1;
      tick(); clear_in();
      for (int i = 0; i < 3; i++) begin
         chk("drain_sqif", 32'(squash_if), 1);
         chk("drain_halt", 32'(halt), 0);
         resume = (i == 0);
         tick();
         resume = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         chk("halted_halt", 32'(halt), 1);
         chk("halted_stall_if", 32'(stall_if), 1);
         tick();
      end
      chk("halted_sqif", 32'(squash_if), 1);
      resume = 1'b1;
      tick(); resume = 1'b0;
      chk("resume_halt", 32'(halt), 0);
      chk("resume_busy", 32'(busy), 0);
      chk("resume_stall_if", 32'(stall_if), 0);

      // All three events, no stalls: EXT wins (1 word).
      id_is_extended = 1'b1; id_is_control = 1'b1; id_is_halt = 1'b1; id_ext_words = 2'd1;
      tick(); clear_in();
      chk("simul_ext_ld", 32'(extended_ld), 1);
      chk("simul_ext_sqif", 32'(squash_if), 0);
      tick();
      chk("simul_ext_done", 32'(busy), 0);

      // All three with EX stall: CTRL taken, squash_ex one cycle later.
      id_is_extended = 1'b1; id_is_control = 1'b1; id_is_halt = 1'b1;
      id_ext_words = 2'd2; vfu_stall_at_ex = 1'b1;
      #1;
      chk("simul_stall_id", 32'(stall_id), 1);
      chk("simul_stall_if", 32'(stall_if), 0);
      tick(); clear_in();
      chk("simul_ctrl_sqif", 32'(squash_if), 1);
      chk("simul_ctrl_ld", 32'(extended_ld), 0);
      chk("simul_sqex", 32'(squash_ex), 1);
      chk("simul_sqid", 32'(squash_id), 0);
      tick();
      chk("simul_sqex_gone", 32'(squash_ex), 0);
      chk("simul_ctrl_sqif1", 32'(squash_if), 1);
      tick();
      chk("simul_ctrl_done", 32'(busy), 0);

      // Zero extension words behave as one.
      id_is_extended = 1'b1; id_ext_words = 2'd0;
      tick(); clear_in();
      chk("ext0_ld", 32'(extended_ld), 1);
      chk("ext0_idx", 32'(ext_index), 0);
      tick();
      chk("ext0_done", 32'(extended_ld), 0);

      // Async reset mid-DRAIN.
      id_is_halt = 1'b1;
      tick(); clear_in();
      chk("ardrain_busy_pre", 32'(busy), 1);
      #2 reset = 1'b0; vfu_stall_at_id = 1'b1;
      #1;
      chk("ardrain_busy", 32'(busy), 0);
      chk("ardrain_sqif", 32'(squash_if), 0);
      chk("ardrain_stall_if", 32'(stall_if), 1);
      tick(); reset = 1'b1; vfu_stall_at_id = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("ardrain_no_halt", 32'(halt), 0);
      chk("ardrain_idle", 32'(busy), 0);

      // Async reset mid-EXT.
      id_is_extended = 1'b1; id_ext_words = 2'd3;
      tick(); clear_in();
      tick();
      chk("arext_idx_pre", 32'(ext_index), 1);
      #2 reset = 1'b0;
      #1;
      chk("arext_ld", 32'(extended_ld), 0);
      chk("arext_sqid", 32'(squash_id), 0);
      chk("arext_idx", 32'(ext_index), 0);
      chk("arext_busy", 32'(busy), 0);
      tick(); reset = 1'b1;
      tick();
      chk("arext_after", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_flow_ctrl.md
Name: pipeline_flow_ctrl

Overview:
- Parametrised successor to the IF/ID flow controller in the 16-bit RISC pipeline.
- Sits between the ID decoder, the value-forwarding control unit and the IF/ID/EX pipeline registers.
- Generalises three things: multi-word extended instructions (1..N extension words), configurable post-control squash length, and configurable halt drain depth.
- Adds a sticky HALTED state that holds the front end until an explicit resume pulse.

Parameters:
EXT_CNT_W, 2, width of id_ext_words; max extension words = 2^EXT_CNT_W-1
CTRL_SQUASH, 1, IF squash cycles after a control instruction (>=1)
HALT_DRAIN, 3, IF squash cycles after halt before halt asserts (>=1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
id_is_extended  input  1  ID holds an extended instruction
id_ext_words  input  EXT_CNT_W  extension word count for the ID instruction; 0 is treated as 1
id_is_control  input  1  ID holds a control-flow instruction
id_is_halt  input  1  ID holds a halt
vfu_stall_at_id  input  1  forwarding unit: ID must wait
vfu_stall_at_ex  input  1  forwarding unit: EX must wait
resume  input  1  single-cycle pulse that leaves HALTED
stall_if  output  1  hold the IF register
stall_id  output  1  hold the ID register
squash_if  output  1  bubble IF
squash_id  output  1  bubble ID
squash_ex  output  1  bubble EX
extended_ld  output  1  current fetched word is an extension word
ext_index  output  EXT_CNT_W  0-based index of the extension word being loaded
halt  output  1  processor halted
busy  output  1  FSM not in RUN

Behaviour:
- States: RUN, EXT, CTRL, DRAIN, HALTED. Encodings live in the shared package. A single down-counter cnt is loaded by the FSM.
- RUN transitions, in priority order:
  - id_is_extended & ~vfu_stall_at_ex -> EXT; cnt = max(id_ext_words,1)-1; ext_index = 0.
  - else id_is_control & ~vfu_stall_at_id -> CTRL; cnt = CTRL_SQUASH-1.
  - else id_is_halt & ~vfu_stall_at_ex -> DRAIN; cnt = HALT_DRAIN-1.
  - else stay in RUN.
- EXT:
  - extended_ld=1 and squash_id=1 every cycle.
  - cnt==0 -> RUN; otherwise cnt decrements and ext_index increments.
  - A 3-word extension occupies EXT for exactly 3 cycles.
- CTRL: squash_if=1; cnt==0 -> RUN, otherwise decrement.
- DRAIN: squash_if=1; cnt==0 -> HALTED, otherwise decrement.
- HALTED:
  - halt=1, squash_if=1, stall_if=1.
  - resume=1 -> RUN on the next edge.
  - resume is ignored in every other state.
- Outside RUN, the id_* inputs are ignored. A new extended/control/halt is not accepted until the state is back in RUN.
- Simultaneous events: the RUN priority order above applies. The vfu stall qualifiers block the transition only; stall outputs still follow the vfu inputs.
- Combinational outputs:
  - stall_id = vfu_stall_at_ex.
  - stall_if = (vfu_stall_at_ex & ~id_is_control) | vfu_stall_at_id | (state==HALTED).
  - squash_id = (state==EXT) | vfu_squash_q.
  - busy = (state!=RUN).
- Registered outputs, updated every rising edge:
  - squash_ex <= vfu_stall_at_ex.
  - vfu_squash_q <= vfu_stall_at_id & ~vfu_stall_at_ex.
- Reset (reset=0, at any time, including mid-EXT, mid-DRAIN or HALTED), effective immediately:
  - state=RUN, cnt=0, ext_index=0, squash_ex=0, vfu_squash_q=0.
  - Hence squash_if=0, squash_id=0, extended_ld=0, halt=0, busy=0.
  - stall_if and stall_id still follow the vfu inputs.
- Counter width = clog2(max(2^EXT_CNT_W, CTRL_SQUASH, HALT_DRAIN))+1. The counter never wraps; loads are clamped to its range.
- Parameter defaults reproduce the legacy controller's timing: 1-word extension, 1 control squash, 3-cycle halt. The one difference is that halt is now sticky.

Decomposition:
- Shared package/header flow_ctrl_pkg: state encoding constants, and clog2 helper function.
- One sub-module flow_cycle_counter: load/decrement counter, parametrised width, zero flag, async active-low reset.

Test Plan:
- Extended, 3 words, no stalls: id_is_extended=1, id_ext_words=3 for one cycle -> extended_ld=1 and squash_id=1 for 3 cycles with ext_index 0,1,2; then busy=0.
- Control, CTRL_SQUASH=2: id_is_control=1 -> squash_if=1 for exactly 2 cycles; with vfu_stall_at_id=1 instead -> no transition and stall_if=1.
- Halt and resume, defaults: id_is_halt=1 -> squash_if=1 for 3 cycles, then halt=1 and stall_if=1 held for 10 cycles; resume pulse -> halt=0 next cycle and state RUN.
- Simultaneous events: id_is_extended=1, id_is_control=1, id_is_halt=1, no stalls -> EXT taken; with vfu_stall_at_ex=1 -> CTRL taken and squash_ex=1 one cycle later.
- VFU bubbles: vfu_stall_at_id=1, vfu_stall_at_ex=0 for one cycle -> squash_id=1 the following cycle only; id_ext_words=0 -> single-cycle EXT.
- Async reset: assert reset=0 mid-DRAIN and mid-EXT between clock edges -> busy, squash_if and extended_ld drop immediately; no halt after release.
